// File: rtl/fir_sram_ctrl_if.sv
// Bus bundle between the FIR delay-line controller, the sample source,
// the MAC tap consumer and the SRAM macro pins.
interface fir_sram_ctrl_if #(
    parameter int DW     = 20,
    parameter int AW     = 11,
    parameter int N_TAPS = 32
);
    localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    // sample input handshake
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;

    // tap stream towards the MAC
    logic             tap_valid;
    logic [DW-1:0]    tap_data;
    logic [TAP_W-1:0] tap_idx;
    logic             tap_last;
    logic             busy;

    // SRAM macro pins
    logic [AW-1:0]    sram_A;
    logic [DW-1:0]    sram_D;
    logic             sram_WEN;
    logic             sram_CEN;
    logic [DW-1:0]    sram_Q;

    // controller view
    modport master (
        input  in_valid, in_data, sram_Q,
        output in_ready, tap_valid, tap_data, tap_idx, tap_last, busy,
               sram_A, sram_D, sram_WEN, sram_CEN
    );

    // environment view (sample source, MAC and SRAM)
    modport slave (
        output in_valid, in_data, sram_Q,
        input  in_ready, tap_valid, tap_data, tap_idx, tap_last, busy,
               sram_A, sram_D, sram_WEN, sram_CEN
    );
endinterface

// File: rtl/fir_sram_ctrl.sv
// FIR delay-line controller: uses a single-port SRAM as a circular sample
// buffer. Each accepted sample is written at wr_ptr, then N_TAPS reads walk
// from the newest sample to the oldest and stream out as taps.
// Optional macro SRAM_CTRL_CLEAR_EN: after reset, zero-fill the whole SRAM
// before the first sample is accepted.
module fir_sram_ctrl #(
    parameter int DW     = 20,
    parameter int AW     = 11,
    parameter int N_TAPS = 32
) (
    input  logic           clk,
    input  logic           reset,
    fir_sram_ctrl_if.master bus
);
    localparam int DEPTH = 1 << AW;
    localparam int TAP_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [TAP_W-1:0] LAST_K = TAP_W'(N_TAPS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
`ifdef SRAM_CTRL_CLEAR_EN
    localparam logic [1:0] S_CLEAR  = 2'd3;
    localparam logic [1:0] S_RESET  = S_CLEAR;
    localparam logic [AW:0] CLR_END = (AW+1)'(DEPTH);
    logic [AW:0]      clr_cnt;
`else
    localparam logic [1:0] S_RESET  = S_IDLE;
`endif

    logic [1:0]       state;
    logic [AW-1:0]    wr_ptr;
    logic [TAP_W-1:0] rd_k;

    // address stage: registered SRAM pins
    logic [AW-1:0]    sram_a_p0;
    logic [DW-1:0]    sram_d_p0;
    logic             sram_wen_p0;
    logic             sram_cen_p0;

    // read-tag stage: aligned with sram_Q
    logic             vld_p1;
    logic [TAP_W-1:0] idx_p1;
    logic             last_p1;

    // tap output stage
    logic             vld_p2;
    logic [DW-1:0]    data_p2;
    logic [TAP_W-1:0] idx_p2;
    logic             last_p2;

    // Sequencer: one write then N_TAPS reads per sample; SRAM pins are set
    // one edge ahead so they are valid during the state that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RESET;
            wr_ptr      <= '0;
            rd_k        <= '0;
            sram_a_p0   <= '0;
            sram_d_p0   <= '0;
            sram_wen_p0 <= 1'b1;
            sram_cen_p0 <= 1'b1;
`ifdef SRAM_CTRL_CLEAR_EN
            clr_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    sram_cen_p0 <= 1'b1;
                    sram_wen_p0 <= 1'b1;
                    sram_d_p0   <= '0;
                    if (bus.in_valid) begin
                        state       <= S_WRITE;
                        sram_cen_p0 <= 1'b0;
                        sram_wen_p0 <= 1'b0;
                        sram_a_p0   <= wr_ptr;
                        sram_d_p0   <= bus.in_data;
                    end
                end
                S_WRITE: begin
                    state       <= S_READ;
                    rd_k        <= '0;
                    sram_cen_p0 <= 1'b0;
                    sram_wen_p0 <= 1'b1;
                    sram_a_p0   <= wr_ptr;
                    sram_d_p0   <= '0;
                end
                S_READ: begin
                    if (rd_k == LAST_K) begin
                        state       <= S_IDLE;
                        wr_ptr      <= wr_ptr + AW'(1);
                        sram_cen_p0 <= 1'b1;
                        sram_wen_p0 <= 1'b1;
                        sram_d_p0   <= '0;
                    end else begin
                        rd_k      <= rd_k + TAP_W'(1);
                        // walk backwards in time; wraps below 0 to DEPTH-1
                        sram_a_p0 <= wr_ptr - AW'(rd_k) - AW'(1);
                    end
                end
`ifdef SRAM_CTRL_CLEAR_EN
                S_CLEAR: begin
                    if (clr_cnt == CLR_END) begin
                        state       <= S_IDLE;
                        wr_ptr      <= '0;
                        sram_cen_p0 <= 1'b1;
                        sram_wen_p0 <= 1'b1;
                        sram_d_p0   <= '0;
                    end else begin
                        clr_cnt     <= clr_cnt + (AW+1)'(1);
                        sram_cen_p0 <= 1'b0;
                        sram_wen_p0 <= 1'b0;
                        sram_a_p0   <= clr_cnt[AW-1:0];
                        sram_d_p0   <= '0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tap pipeline: tag each read, then capture sram_Q with the delayed tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            idx_p2  <= '0;
            last_p2 <= 1'b0;
        end else begin
            // ---- address cycle -> SRAM data cycle ----
            vld_p1  <= (state == S_READ);
            idx_p1  <= rd_k;
            last_p1 <= (state == S_READ) && (rd_k == LAST_K);
            // ---- SRAM data cycle -> tap output ----
            vld_p2  <= vld_p1;
            idx_p2  <= idx_p1;
            last_p2 <= last_p1;
            if (vld_p1) begin
                data_p2 <= bus.sram_Q;
            end
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE) || vld_p1 || vld_p2;
    assign bus.tap_valid = vld_p2;
    assign bus.tap_data  = data_p2;
    assign bus.tap_idx   = idx_p2;
    assign bus.tap_last  = last_p2;
    assign bus.sram_A    = sram_a_p0;
    assign bus.sram_D    = sram_d_p0;
    assign bus.sram_WEN  = sram_wen_p0;
    assign bus.sram_CEN  = sram_cen_p0;
endmodule

// File: tb/tb_fir_sram_ctrl.sv
// Scoreboard bench for fir_sram_ctrl (DW=20, AW=3, N_TAPS=4) with a
// behavioural single-port SRAM and a circular-buffer reference model.
module tb_fir_sram_ctrl;
    localparam int DW     = 20;
    localparam int AW     = 3;
    localparam int N_TAPS = 4;
    localparam int DEPTH  = 1 << AW;
    localparam int TAP_W  = 2;

    typedef struct {
        logic [DW-1:0]    data;
        logic [TAP_W-1:0] idx;
        logic             last;
        int               cyc;
    } tap_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fir_sram_ctrl_if #(.DW(DW), .AW(AW), .N_TAPS(N_TAPS)) bus();

    fir_sram_ctrl #(.DW(DW), .AW(AW), .N_TAPS(N_TAPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'(i * 32'h2F1B + 32'h91357);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural SRAM: registered read, contents preset on first edge
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] sram_q = '0;
    logic          sram_init = 1'b0;
    assign bus.sram_Q = sram_q;
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < DEPTH; i++) sram_mem[i] <= init_word(i);
            sram_init <= 1'b1;
        end else if (!bus.sram_CEN) begin
            if (!bus.sram_WEN) sram_mem[bus.sram_A] <= bus.sram_D;
            else               sram_q <= sram_mem[bus.sram_A];
        end
    end

    // reference model: circular delay line + expected events
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] ref_ptr = '0;
    logic          model_init = 1'b0;
    logic          mon_en = 1'b0;
    int            acc_cyc = -100;
    int            clr_end = -100;
    logic          b2b = 1'b0;
    logic          b2b_seen = 1'b0;
    int            b2b_prev = 0;
    tap_t          exp_taps [$];
    wr_t           exp_wr [$];

    always @(posedge clk) begin
        tap_t          tp;
        wr_t           wr;
        logic [AW-1:0] a;
        if (!model_init) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] <= init_word(i);
            model_init <= 1'b1;
        end
        if (!b2b) b2b_seen <= 1'b0;
        if (reset) begin
            mon_en  <= 1'b1;
            exp_taps.delete();
            exp_wr.delete();
            ref_ptr <= '0;
            acc_cyc <= -100;
`ifdef SRAM_CTRL_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i] <= '0;
                wr.addr = AW'(i);
                wr.data = '0;
                wr.cyc  = cyc + 2 + i;
                exp_wr.push_back(wr);
            end
            clr_end <= cyc + 1 + DEPTH;
`endif
        end else if (bus.in_valid && bus.in_ready) begin
            wr.addr = ref_ptr;
            wr.data = bus.in_data;
            wr.cyc  = cyc + 1;
            exp_wr.push_back(wr);
            for (int k = 0; k < N_TAPS; k++) begin
                a       = ref_ptr - AW'(k);
                tp.data = (k == 0) ? bus.in_data : ref_mem[a];
                tp.idx  = TAP_W'(k);
                tp.last = (k == N_TAPS - 1);
                tp.cyc  = cyc + 4 + k;
                exp_taps.push_back(tp);
            end
            ref_mem[ref_ptr] <= bus.in_data;
            ref_ptr <= ref_ptr + AW'(1);
            acc_cyc <= cyc;
            if (b2b) begin
                if (b2b_seen) check("accept_spacing", cyc - b2b_prev, N_TAPS + 2);
                b2b_prev <= cyc;
                b2b_seen <= 1'b1;
            end
        end
    end

    // monitor: compares DUT outputs against the queued expectations
    always @(negedge clk) begin
        tap_t tp;
        wr_t  wr;
        logic exp_busy, exp_ready, wr_act, in_clr;
        if (mon_en) begin
            in_clr    = (cyc <= clr_end);
            exp_busy  = ((cyc >= acc_cyc + 1) && (cyc <= acc_cyc + 3 + N_TAPS)) || in_clr;
            exp_ready = !((cyc >= acc_cyc + 1) && (cyc <= acc_cyc + 1 + N_TAPS)) && !in_clr;
            check("in_ready", bus.in_ready, exp_ready);
            check("busy", bus.busy, exp_busy);

            if (bus.tap_valid) begin
                if (exp_taps.size() == 0) begin
                    check("tap_unexpected", bus.tap_valid, 0);
                end else begin
                    tp = exp_taps.pop_front();
                    check("tap_data", bus.tap_data, tp.data);
                    check("tap_idx", bus.tap_idx, tp.idx);
                    check("tap_last", bus.tap_last, tp.last);
                    check("tap_cycle", cyc, tp.cyc);
                end
            end else if (exp_taps.size() != 0 && exp_taps[0].cyc <= cyc) begin
                tp = exp_taps.pop_front();
                check("tap_missing", bus.tap_valid, 1);
            end

            wr_act = !bus.sram_CEN && !bus.sram_WEN;
            if (wr_act) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", wr_act, 0);
                end else begin
                    wr = exp_wr.pop_front();
                    check("wr_addr", bus.sram_A, wr.addr);
                    check("wr_data", bus.sram_D, wr.data);
                    check("wr_cycle", cyc, wr.cyc);
                end
            end else if (exp_wr.size() != 0 && exp_wr[0].cyc <= cyc) begin
                wr = exp_wr.pop_front();
                check("wr_missing", wr_act, 1);
            end
        end
    end

    task automatic send(input logic [DW-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("send_timeout", bus.in_ready, 1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef SRAM_CTRL_CLEAR_EN
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_busy", bus.busy, 1);
`else
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_busy", bus.busy, 0);
`endif
        check("rst_cen", bus.sram_CEN, 1);
        check("rst_wen", bus.sram_WEN, 1);
        check("rst_addr", bus.sram_A, 0);
        check("rst_tap_valid", bus.tap_valid, 0);
        check("rst_tap_idx", bus.tap_idx, 0);
        reset = 1'b0;

        // single sample
        send(20'd5);
        idle(12);

        // back-to-back samples 1..12 from a fresh pointer, in_valid held high
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        b2b = 1'b1;
        for (int v = 1; v <= 12; v++) send(DW'(v));
        bus.in_valid = 1'b0;
        b2b = 1'b0;
        idle(12);

        // in_valid pulse with 99 during READ must be ignored
        send(20'd33);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 20'd99;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        idle(12);

        // randomized traffic, including offers while busy
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            bus.in_valid = ($urandom_range(0, 2) == 0);
            bus.in_data  = DW'($urandom);
        end
        idle(14);

        // reset during READ k = 2
        send(20'd7);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_tap_valid", bus.tap_valid, 0);
        check("midrst_cen", bus.sram_CEN, 1);
`ifndef SRAM_CTRL_CLEAR_EN
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", bus.busy, 0);
`endif
        idle(10);
        send(20'd21);
        idle(14);

        check("taps_drained", exp_taps.size(), 0);
        check("writes_drained", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
